dual_psum_accum: RTL

Downstream stage of the packed dual-product DSP multiplier. Each cycle that DSP yields two signed 16-bit products (one per filter) sharing one operand; this block aligns them with the multiplier pipeline and accumulates ACC_LEN products per filter over one convolution window (3x3x128 by default). It emits both full-width sums plus requantized int8 results with a one-cycle valid strobe.

---
 rtl/mac_pkg.sv | 21 ++
 rtl/dual_psum_accum_if.sv | 27 ++
 rtl/requant_sat.sv | 15 +
 rtl/dual_psum_accum.sv | 79 +++++++
 4 files changed

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared widths, int8 limits and requantization for the dual-product MAC stage
package mac_pkg;

   localparam int ACC_W_DEF = 32;
   localparam int PROD_W    = 16;
   localparam int Q_W       = 8;
   localparam int Q_MIN     = -128;
   localparam int Q_MAX     = 127;

   // Round-half-up arithmetic shift, then clamp to int8; 64-bit working width never overflows.
   function automatic logic signed [Q_W-1:0] requant(input logic signed [63:0] s, input int shift);
      logic signed [63:0] r;
      r = s;
      if (shift > 0) r = r + (64'sd1 <<< (shift - 1));
      r = r >>> shift;
      if (r > 64'(Q_MAX)) return Q_W'(Q_MAX);
      if (r < 64'(Q_MIN)) return Q_W'(Q_MIN);
      return r[Q_W-1:0];
   endfunction

endpackage

// File: rtl/dual_psum_accum_if.sv
// rtl/dual_psum_accum_if.sv - product input and window-result bundle for dual_psum_accum
interface dual_psum_accum_if
   import mac_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF
);
   logic                     issue_valid;
   logic                     flush;
   logic signed [PROD_W-1:0] prod1;
   logic signed [PROD_W-1:0] prod2;
   logic                     sum_valid;
   logic signed [ACC_W-1:0]  sum1;
   logic signed [ACC_W-1:0]  sum2;
   logic signed [Q_W-1:0]    q1;
   logic signed [Q_W-1:0]    q2;
   logic                     busy;

   modport master (
      output issue_valid, flush, prod1, prod2,
      input  sum_valid, sum1, sum2, q1, q2, busy
   );

   modport slave (
      input  issue_valid, flush, prod1, prod2,
      output sum_valid, sum1, sum2, q1, q2, busy
   );
endinterface

// File: rtl/requant_sat.sv
// rtl/requant_sat.sv - combinational requantize-and-saturate of one signed window sum to int8
module requant_sat
   import mac_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF,
   parameter int SHIFT = 8
) (
   input  logic signed [ACC_W-1:0] s,
   output logic signed [Q_W-1:0]   q
);
   logic signed [63:0] s_ext;

   assign s_ext = {{(64 - ACC_W){s[ACC_W-1]}}, s};
   assign q     = requant(s_ext, SHIFT);
endmodule

// File: rtl/dual_psum_accum.sv
// rtl/dual_psum_accum.sv - aligns packed-DSP product pairs and accumulates them per window
module dual_psum_accum
   import mac_pkg::*;
#(
   parameter int DSP_LAT = 3,
   parameter int ACC_LEN = 1152,
   parameter int ACC_W   = ACC_W_DEF,
   parameter int SHIFT   = 8
) (
   input logic              clk,
   input logic              rst_n,
   dual_psum_accum_if.slave bus
);
   localparam int               CNT_W = $clog2(ACC_LEN);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(ACC_LEN - 1);

   logic [DSP_LAT-1:0]      dly;
   logic                    pv;
   logic [CNT_W-1:0]        cnt;
   logic signed [ACC_W-1:0] acc1, acc2;
   logic signed [ACC_W-1:0] p1, p2;
   logic signed [ACC_W-1:0] tot1, tot2;
   logic signed [ACC_W-1:0] sum1_r, sum2_r;
   logic signed [Q_W-1:0]   qn1, qn2;
   logic signed [Q_W-1:0]   q1_r, q2_r;
   logic                    sum_valid_r;

   assign pv   = dly[DSP_LAT-1];
   assign p1   = {{(ACC_W - PROD_W){bus.prod1[PROD_W-1]}}, bus.prod1};
   assign p2   = {{(ACC_W - PROD_W){bus.prod2[PROD_W-1]}}, bus.prod2};
   assign tot1 = acc1 + p1;
   assign tot2 = acc2 + p2;

   requant_sat #(.ACC_W(ACC_W), .SHIFT(SHIFT)) u_rq1 (.s(tot1), .q(qn1));
   requant_sat #(.ACC_W(ACC_W), .SHIFT(SHIFT)) u_rq2 (.s(tot2), .q(qn2));

   // A window's first product loads the accumulator, so no clear is needed between windows.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dly         <= '0;
         cnt         <= '0;
         acc1        <= '0;
         acc2        <= '0;
         sum1_r      <= '0;
         sum2_r      <= '0;
         q1_r        <= '0;
         q2_r        <= '0;
         sum_valid_r <= 1'b0;
      end else if (bus.flush) begin
         dly         <= '0;
         cnt         <= '0;
         sum_valid_r <= 1'b0;
      end else begin
         dly         <= (dly << 1) | DSP_LAT'(bus.issue_valid);
         sum_valid_r <= 1'b0;
         if (pv) begin
            acc1 <= (cnt == '0) ? p1 : tot1;
            acc2 <= (cnt == '0) ? p2 : tot2;
            if (cnt == LAST) begin
               sum1_r      <= tot1;
               sum2_r      <= tot2;
               q1_r        <= qn1;
               q2_r        <= qn2;
               sum_valid_r <= 1'b1;
               cnt         <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

   assign bus.sum_valid = sum_valid_r;
   assign bus.sum1      = sum1_r;
   assign bus.sum2      = sum2_r;
   assign bus.q1        = q1_r;
   assign bus.q2        = q2_r;
   assign bus.busy      = (cnt != '0);
endmodule
